run_step_controller: RTL

RUN_STEP_CONTROLLER -- requirements
Module: run_step_controller

---
 rtl/run_step_pkg.sv | 14 +
 rtl/rate_divider.sv | 30 +++
 rtl/run_step_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/run_step_pkg.sv
// Shared state encoding and default widths for the run/step controller.
package run_step_pkg;

   localparam int DEF_RATE_W = 26;
   localparam int DEF_PC_W   = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_STEP  = 2'b01,
      ST_RUN   = 2'b10,
      ST_BREAK = 2'b11
   } run_state_t;

endpackage

// File: rtl/rate_divider.sv
// Free-running period counter: o_tick is high combinationally on the cycle the count equals i_divisor.
// A count already above a newly lowered divisor keeps climbing and wraps through zero without a tick.
module rate_divider
   import run_step_pkg::*;
#(
   parameter int RATE_W = DEF_RATE_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_enable,
   input  logic [RATE_W-1:0] i_divisor,
   output logic              o_tick
);

   logic [RATE_W-1:0] r_cnt;

   assign o_tick = i_enable & (r_cnt == i_divisor);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= o_tick ? '0 : r_cnt + RATE_W'(1);
      end
   end

endmodule

// File: rtl/run_step_controller.sv
// Run/step/halt sequencer issuing one registered o_proc_en pulse per processor step; no backpressure.
// Define RUN_STEP_BKPT_EN to build the PC breakpoint compare and the BREAK state.
module run_step_controller
   import run_step_pkg::*;
#(
   parameter int RATE_W = DEF_RATE_W,
   parameter int PC_W   = DEF_PC_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_step_strobe,
   input  logic              i_run_req,
   input  logic              i_halt_req,
   input  logic [RATE_W-1:0] i_divisor,
   input  logic              i_bkpt_en,
   input  logic [PC_W-1:0]   i_bkpt_pc,
   input  logic [PC_W-1:0]   i_pc,
   output logic              o_proc_en,
   output logic [1:0]        o_mode,
   output logic              o_halted,
   output logic [15:0]       o_step_count
);

   run_state_t  r_state;
   run_state_t  w_state_nxt;
   logic        r_proc_en;
   logic [15:0] r_step_cnt;
   logic        w_pulse_nxt;
   logic        w_div_en;
   logic        w_div_clear;
   logic        w_tick;
   logic        w_bkpt_hit;

   // The divider only keeps its count while RUN is being held; any exit clears it.
   assign w_div_en    = (r_state == ST_RUN);
   assign w_div_clear = !(w_div_en && i_run_req && !i_halt_req);

`ifdef RUN_STEP_BKPT_EN
   assign w_bkpt_hit = i_bkpt_en && (i_pc == i_bkpt_pc);
   assign o_halted   = (r_state == ST_BREAK);
`else
   logic w_unused_bkpt;
   assign w_unused_bkpt = &{1'b0, i_bkpt_en, i_bkpt_pc, i_pc};
   assign w_bkpt_hit    = 1'b0;
   assign o_halted      = 1'b0;
`endif

   rate_divider #(.RATE_W(RATE_W)) u_rate_divider (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (w_div_clear),
      .i_enable  (w_div_en),
      .i_divisor (i_divisor),
      .o_tick    (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pulse_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_halt_req) begin
               w_state_nxt = ST_IDLE;
            end else if (i_step_strobe) begin
               w_state_nxt = ST_STEP;
               w_pulse_nxt = 1'b1;
            end else if (i_run_req) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_STEP: begin
            w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (i_halt_req || !i_run_req) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tick) begin
               if (w_bkpt_hit) begin
                  w_state_nxt = ST_BREAK;
               end else begin
                  w_pulse_nxt = 1'b1;
               end
            end
         end
         ST_BREAK: begin
`ifdef RUN_STEP_BKPT_EN
            if (i_halt_req) begin
               w_state_nxt = ST_IDLE;
            end else if (i_step_strobe) begin
               w_state_nxt = ST_STEP;
               w_pulse_nxt = 1'b1;
            end else if (!i_run_req) begin
               w_state_nxt = ST_IDLE;
            end
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_proc_en  <= 1'b0;
         r_step_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_proc_en <= w_pulse_nxt;
         if (w_pulse_nxt) begin
            r_step_cnt <= r_step_cnt + 16'd1;
         end
      end
   end

   assign o_proc_en    = r_proc_en;
   assign o_mode       = r_state;
   assign o_step_count = r_step_cnt;

endmodule
